// File: rtl/mandel_pkg.sv
// Shared types, constants and colour mapping for the Mandelbrot pixel engine.
package mandel_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_FRAC  = 12;

    typedef logic signed [DEF_WIDTH-1:0] fixed_t;

    typedef enum logic [2:0] {IDLE, INIT, ITER, PLOT, DONE} state_t;

    localparam int ESCAPE_R2 = 4 << DEF_FRAC;

    function automatic logic [2:0] escape_colour(input int unsigned iter);
        return 3'((iter % 7) + 1);
    endfunction

endpackage

// File: rtl/mandel_iter_step.sv
// One combinational z = z^2 + c step with the |z|^2 > 4 escape test.
module mandel_iter_step #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic signed [WIDTH-1:0] zr,
    input  logic signed [WIDTH-1:0] zi,
    input  logic signed [WIDTH-1:0] cr,
    input  logic signed [WIDTH-1:0] ci,
    output logic signed [WIDTH-1:0] zr_next,
    output logic signed [WIDTH-1:0] zi_next,
    output logic                    escaped
);

    localparam int PW = 2 * WIDTH;
    localparam int MW = WIDTH + 4;
    localparam logic [MW-1:0] ESC = MW'(4) << FRAC;

    logic signed [PW-1:0] zr_w, zi_w, p_rr, p_ii, p_ri, zr2, zi2, zri;
    logic        [MW-1:0] mag2;

    always_comb begin
        zr_w = PW'(zr);
        zi_w = PW'(zi);
        p_rr = zr_w * zr_w;
        p_ii = zi_w * zi_w;
        p_ri = zr_w * zi_w;
        zr2  = p_rr >>> FRAC;
        zi2  = p_ii >>> FRAC;
        zri  = p_ri >>> (FRAC - 1);
        // Squares are non-negative, so an unsigned sum at MW bits cannot wrap
        mag2    = MW'(zr2) + MW'(zi2);
        escaped = mag2 > ESC;
        zr_next = WIDTH'(zr2 - zi2 + PW'(cr));
        zi_next = WIDTH'(zri + PW'(ci));
    end

endmodule

// File: rtl/mandel_pixel_engine.sv
// Raster-scan Mandelbrot escape-time renderer feeding vga_adapter (160x120).
// Optional MANDEL_PAN_EN adds re_origin/im_origin inputs latched per frame.
module mandel_pixel_engine
    import mandel_pkg::*;
#(
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int WIDTH    = 16,
    parameter int FRAC     = 12,
    parameter int MAX_ITER = 31,
    parameter int RE_MIN   = -8192,
    parameter int RE_STEP  = 77,
    parameter int IM_MAX   = 5120,
    parameter int IM_STEP  = 85
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    start,
`ifdef MANDEL_PAN_EN
    input  logic signed [WIDTH-1:0] re_origin,
    input  logic signed [WIDTH-1:0] im_origin,
`endif
    output logic [7:0]              x,
    output logic [6:0]              y,
    output logic [2:0]              colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);

    localparam int IW = $clog2(MAX_ITER + 1);
    localparam logic signed [WIDTH-1:0] RE_STEP_F = WIDTH'(RE_STEP);
    localparam logic signed [WIDTH-1:0] IM_STEP_F = WIDTH'(IM_STEP);

    state_t state, state_nx;

    logic signed [WIDTH-1:0] zr, zi, cr, ci, zr_nx, zi_nx;
    logic signed [WIDTH-1:0] frame_re, frame_im, row_re;
    logic [IW-1:0]           iter;
    logic                    escaped, at_cap, last_col, last_row;

`ifdef MANDEL_PAN_EN
    logic signed [WIDTH-1:0] re_org_q;
    assign frame_re = re_origin;
    assign frame_im = im_origin;
    assign row_re   = re_org_q;
`else
    assign frame_re = WIDTH'(RE_MIN);
    assign frame_im = WIDTH'(IM_MAX);
    assign row_re   = WIDTH'(RE_MIN);
`endif

    mandel_iter_step #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_step (
        .zr      (zr),
        .zi      (zi),
        .cr      (cr),
        .ci      (ci),
        .zr_next (zr_nx),
        .zi_next (zi_nx),
        .escaped (escaped)
    );

    assign at_cap   = (iter == IW'(MAX_ITER));
    assign last_col = (x >= 8'(X_MAX));
    assign last_row = (y >= 7'(Y_MAX));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = INIT;
            INIT:       state_nx = ITER;
            ITER:       if (escaped || at_cap) state_nx = PLOT;
            PLOT:       state_nx = (last_col && last_row) ? DONE : INIT;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
            zr     <= '0;
            zi     <= '0;
            cr     <= '0;
            ci     <= '0;
            iter   <= '0;
`ifdef MANDEL_PAN_EN
            re_org_q <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        x  <= '0;
                        y  <= '0;
                        cr <= frame_re;
                        ci <= frame_im;
`ifdef MANDEL_PAN_EN
                        re_org_q <= re_origin;
`endif
                    end
                end
                INIT: begin
                    zr   <= '0;
                    zi   <= '0;
                    iter <= '0;
                end
                ITER: begin
                    if (escaped) begin
                        colour <= escape_colour(32'(iter));
                    end else if (at_cap) begin
                        colour <= '0;
                    end else begin
                        zr   <= zr_nx;
                        zi   <= zi_nx;
                        iter <= iter + IW'(1);
                    end
                end
                PLOT: begin
                    // c advances by accumulation; rows restart from the latched origin
                    if (!last_col) begin
                        x  <= x + 8'd1;
                        cr <= cr + RE_STEP_F;
                    end else if (!last_row) begin
                        x  <= '0;
                        y  <= y + 7'd1;
                        cr <= row_re;
                        ci <= ci - IM_STEP_F;
                    end
                end
                default: ;
            endcase
        end
    end

    assign plot = (state == PLOT);
    assign busy = (state == INIT) || (state == ITER) || (state == PLOT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mandel_pixel_engine.sv
// Self-checking bench for mandel_pixel_engine using an escape-time reference model.
// Build with MANDEL_PAN_EN defined to also exercise the pan origin inputs.
module tb_mandel_pixel_engine;
    import mandel_pkg::*;

    localparam int TB_XMAX  = 15;
    localparam int TB_YMAX  = 11;
    localparam int TB_RS    = 770;
    localparam int TB_IS    = 850;
    localparam int TB_ITER  = 31;
    localparam int TB_REMIN = -8192;
    localparam int TB_IMMAX = 5120;
    localparam int NPIX     = (TB_XMAX + 1) * (TB_YMAX + 1);

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       start_z = 1'b0;
    logic [7:0] x, x_z;
    logic [6:0] y, y_z;
    logic [2:0] colour, colour_z;
    logic       plot, busy, done, plot_z, busy_z, done_z;
`ifdef MANDEL_PAN_EN
    logic signed [15:0] re_origin = 16'(TB_REMIN);
    logic signed [15:0] im_origin = 16'(TB_IMMAX);
    logic signed [15:0] re_origin_z = '0;
    logic signed [15:0] im_origin_z = '0;
`endif

    always #5 clock = ~clock;

    mandel_pixel_engine #(
        .X_MAX(TB_XMAX), .Y_MAX(TB_YMAX), .WIDTH(16), .FRAC(12), .MAX_ITER(TB_ITER),
        .RE_MIN(TB_REMIN), .RE_STEP(TB_RS), .IM_MAX(TB_IMMAX), .IM_STEP(TB_IS)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start),
`ifdef MANDEL_PAN_EN
        .re_origin(re_origin), .im_origin(im_origin),
`endif
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    // Single-pixel frame at c = 0, which never escapes
    mandel_pixel_engine #(
        .X_MAX(0), .Y_MAX(0), .WIDTH(16), .FRAC(12), .MAX_ITER(TB_ITER),
        .RE_MIN(0), .RE_STEP(0), .IM_MAX(0), .IM_STEP(0)
    ) dut_z (
        .clock(clock), .resetn(resetn), .start(start_z),
`ifdef MANDEL_PAN_EN
        .re_origin(re_origin_z), .im_origin(im_origin_z),
`endif
        .x(x_z), .y(y_z), .colour(colour_z), .plot(plot_z), .busy(busy_z), .done(done_z)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int px;
        int py;
        int col;
        int t;
    } plot_t;

    plot_t plots[$];
    plot_t mon_p;
    int    b2b = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    logic  prev_plot = 1'b0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (resetn && start && !busy) start_cyc = cyc;
        if (plot) begin
            if (prev_plot) b2b++;
            mon_p.px  = int'(x);
            mon_p.py  = int'(y);
            mon_p.col = int'(colour);
            mon_p.t   = cyc;
            plots.push_back(mon_p);
        end
        prev_plot = plot;
    end

    function automatic longint wrap16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return longint'(t);
    endfunction

    // Escape-time reference: k is the iteration at which the pixel resolved
    function automatic void model_pixel(input int px, input int py, input int re0, input int im0,
                                        output int k, output int col);
        longint cr, ci, zr, zi, a, b, p;
        cr = wrap16(longint'(re0) + longint'(px) * TB_RS);
        ci = wrap16(longint'(im0) - longint'(py) * TB_IS);
        zr = 0;
        zi = 0;
        k = 0;
        col = 0;
        for (int it = 0; it <= TB_ITER; it++) begin
            a = (zr * zr) >>> DEF_FRAC;
            b = (zi * zi) >>> DEF_FRAC;
            p = (zr * zi) >>> (DEF_FRAC - 1);
            k = it;
            if (a + b > ESCAPE_R2) begin
                col = (it % 7) + 1;
                return;
            end
            if (it == TB_ITER) begin
                col = 0;
                return;
            end
            zr = wrap16(a - b + cr);
            zi = wrap16(p + ci);
        end
    endfunction

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic verify_frame(input string tag, input int re0, input int im0);
        int n, k, col, prev, t, idx;
        plot_t got;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL %s_done_timeout done=%b required 1", tag, done);
            errors++;
        end
        checks++;
        if (plots.size() != NPIX) begin
            $display("FAIL %s_plot_count got %0d required %0d", tag, plots.size(), NPIX);
            errors++;
        end
        prev = start_cyc;
        idx = 0;
        for (int py = 0; py <= TB_YMAX; py++) begin
            for (int px = 0; px <= TB_XMAX; px++) begin
                model_pixel(px, py, re0, im0, k, col);
                t = prev + k + 3;
                prev = t;
                if (idx < plots.size()) got = plots[idx];
                else got = '{-1, -1, -1, -1};
                checks++;
                if (got.px != px || got.py != py || got.col != col || got.t != t) begin
                    $display("FAIL %s_pixel%0d got x=%0d y=%0d c=%0d t=%0d required x=%0d y=%0d c=%0d t=%0d",
                             tag, idx, got.px, got.py, got.col, got.t, px, py, col, t);
                    errors++;
                end
                idx++;
            end
        end
        checks++;
        if (b2b != 0) begin
            $display("FAIL %s_back_to_back_plot got %0d required 0", tag, b2b);
            errors++;
        end
        checks++;
        if ({busy, done, plot} !== 3'b010) begin
            $display("FAIL %s_done_flags busy/done/plot=%b required 010", tag, {busy, done, plot});
            errors++;
        end
        checks++;
        if (x !== 8'(TB_XMAX) || y !== 7'(TB_YMAX)) begin
            $display("FAIL %s_last_xy got (%0d,%0d) required (%0d,%0d)", tag, x, y, TB_XMAX, TB_YMAX);
            errors++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({x, y, colour} !== '0) begin
            $display("FAIL reset_xyc got x=%0d y=%0d c=%0d required 0", x, y, colour);
            errors++;
        end
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            $display("FAIL reset_flags plot/busy/done=%b required 000", {plot, busy, done});
            errors++;
        end
        @(posedge clock); #1 resetn = 1'b1;
        repeat (10) @(negedge clock);
        checks++;
        if (plots.size() != 0 || busy !== 1'b0) begin
            $display("FAIL idle_after_reset plots=%0d busy=%b required 0 0", plots.size(), busy);
            errors++;
        end
    endtask

    task automatic test_first_pixel();
        int n;
        plots.delete();
        b2b = 0;
        pulse_start();
        n = 0;
        while (!plot && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n != 4) begin
            $display("FAIL first_pixel_latency got %0d required 4", n);
            errors++;
        end
        checks++;
        if (x !== 8'd0 || y !== 7'd0 || colour !== 3'd2) begin
            $display("FAIL first_pixel got x=%0d y=%0d c=%0d required 0 0 2", x, y, colour);
            errors++;
        end
    endtask

    task automatic test_full_frame();
        verify_frame("full_frame", TB_REMIN, TB_IMMAX);
    endtask

    task automatic test_back_to_back();
        plots.delete();
        b2b = 0;
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL restart_from_done busy/done=%b required 10", {busy, done});
            errors++;
        end
        verify_frame("back_to_back", TB_REMIN, TB_IMMAX);
    endtask

    task automatic test_start_ignored();
        plots.delete();
        b2b = 0;
        pulse_start();
        repeat (400) begin
            @(posedge clock); #1;
            start = (busy && $urandom_range(0, 2) == 0);
        end
        start = 1'b0;
        verify_frame("start_spam", TB_REMIN, TB_IMMAX);
    endtask

    task automatic test_interior();
        int n;
        @(posedge clock); #1 start_z = 1'b1;
        @(posedge clock); #1 start_z = 1'b0;
        n = 0;
        while (!plot_z && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n != TB_ITER + 3) begin
            $display("FAIL interior_latency got %0d required %0d", n, TB_ITER + 3);
            errors++;
        end
        checks++;
        if (colour_z !== 3'd0 || x_z !== 8'd0 || y_z !== 7'd0) begin
            $display("FAIL interior_pixel got x=%0d y=%0d c=%0d required 0 0 0", x_z, y_z, colour_z);
            errors++;
        end
        @(negedge clock);
        checks++;
        if ({plot_z, busy_z, done_z} !== 3'b001) begin
            $display("FAIL interior_done plot/busy/done=%b required 001", {plot_z, busy_z, done_z});
            errors++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        plots.delete();
        b2b = 0;
        pulse_start();
        repeat ($urandom_range(20, 300)) @(posedge clock);
        #1;
        if (plot) begin
            @(posedge clock); #1;
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({x, y, colour, plot, busy, done} !== '0) begin
            $display("FAIL async_reset got x=%0d y=%0d c=%0d plot/busy/done=%b required all 0",
                     x, y, colour, {plot, busy, done});
            errors++;
        end
        @(posedge clock); #1 resetn = 1'b1;
        n = plots.size();
        repeat (60) @(negedge clock);
        checks++;
        if (plots.size() != n || busy !== 1'b0) begin
            $display("FAIL no_plot_after_reset plots=%0d busy=%b required %0d 0", plots.size(), busy, n);
            errors++;
        end
        plots.delete();
        b2b = 0;
        pulse_start();
        verify_frame("after_reset", TB_REMIN, TB_IMMAX);
    endtask

`ifdef MANDEL_PAN_EN
    task automatic test_pan();
        int r0, i0;
        re_origin = '0;
        im_origin = '0;
        plots.delete();
        b2b = 0;
        pulse_start();
        repeat ($urandom_range(5, 200)) @(posedge clock);
        #1;
        im_origin = 16'($urandom_range(0, 8000));
        re_origin = 16'($urandom_range(0, 8000));
        verify_frame("pan_zero", 0, 0);
        checks++;
        if (plots.size() == 0 || plots[0].col != 0) begin
            $display("FAIL pan_zero_pixel0 colour got %0d required 0",
                     plots.size() == 0 ? -1 : plots[0].col);
            errors++;
        end
        r0 = -9000 + int'($urandom_range(0, 8000));
        i0 = -2000 + int'($urandom_range(0, 8000));
        re_origin = 16'(r0);
        im_origin = 16'(i0);
        plots.delete();
        b2b = 0;
        pulse_start();
        re_origin = 16'(TB_REMIN);
        im_origin = 16'(TB_IMMAX);
        verify_frame("pan_random", r0, i0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_pixel();
        test_full_frame();
        test_back_to_back();
        test_start_ignored();
        test_interior();
        test_reset_mid_frame();
`ifdef MANDEL_PAN_EN
        test_pan();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
